// File: rtl/cart_mapper_gen.sv
// Table-driven 7800 cartridge mapper: host-loaded window table, up to four
// bank registers, flat / data-write / hotspot banking, ROM reads fetched
// from SDRAM through a request/acknowledge handshake, on-cart RAM and a
// POKEY select.
module cart_mapper_gen #(
  parameter int               WIN_BITS = 3,
  parameter int               BANK_W   = 5,
  parameter int               NREG     = 2,
  parameter int               ROM_AW   = 20,
  parameter int               RAM_AW   = 14,
  parameter logic [11:0]      HOT_BASE = 12'hFF8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          cfg_mode,
  input  logic [BANK_W-1:0]   cfg_bank_mask,
  input  logic [15:0]         cfg_offset,
  input  logic                cfg_we,
  input  logic [WIN_BITS-1:0] cfg_win,
  input  logic [2:0]          cfg_type,
  input  logic [2:0]          cfg_sel,
  input  logic [BANK_W-1:0]   cfg_bank,
  input  logic [15:0]         address_in,
  input  logic [7:0]          din,
  input  logic                rw,
  input  logic                cart_cs,
  input  logic                bus_strobe,
  output logic                rom_req,
  output logic [ROM_AW-1:0]   rom_address,
  input  logic                rom_ack,
  input  logic [7:0]          rom_din,
  output logic [7:0]          dout,
  output logic                dout_oe,
  output logic                pokey_cs,
  output logic                busy,
  output logic                overrun
);

  localparam int NWIN  = 1 << WIN_BITS;
  localparam int LOW_W = 16 - WIN_BITS;
  localparam int ENT_W = 6 + BANK_W;

  localparam logic [2:0] T_FLAT  = 3'd1;
  localparam logic [2:0] T_POKEY = 3'd2;
  localparam logic [2:0] T_RAM   = 3'd3;
  localparam logic [2:0] T_BANK  = 3'd4;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                    state_reg, state_next;
  logic [ROM_AW-1:0]         rom_address_reg, rom_address_next;
  logic [7:0]                dout_reg, dout_next;
  logic                      dout_oe_reg, dout_oe_next;
  logic                      dout_ram_reg, dout_ram_next;
  logic                      overrun_reg, overrun_next;
  logic [7:0]                ram_q_reg;

  logic [NWIN-1:0][ENT_W-1:0] table_vec;
  logic [3:0][BANK_W-1:0]     bank_vec;

  // Decoded view of the current access
  logic                 idle;
  logic                 access;
  logic [WIN_BITS-1:0]  win;
  logic [2:0]           e_type;
  logic [2:0]           e_sel;
  logic [BANK_W-1:0]    e_bank;
  logic                 sel_valid;
  logic [1:0]           sel_idx;
  logic [1:0]           hot_idx;
  logic [BANK_W-1:0]    bank_num;
  logic [15:0]          flat_off;
  logic [ROM_AW+BANK_W+LOW_W-1:0] banked_wide;
  logic [ROM_AW+15:0]   flat_wide;
  logic [ROM_AW-1:0]    rom_addr_calc;
  logic                 upd_data;
  logic                 upd_hot;
  logic                 ram_we;
  logic                 ram_re;
  logic [RAM_AW-1:0]    ram_addr;

  logic [7:0] ram [2**RAM_AW];

  assign idle   = (state_reg == ST_IDLE);
  assign access = bus_strobe & cart_cs;
  assign win    = address_in[15 -: WIN_BITS];
  assign {e_type, e_sel, e_bank} = table_vec[win];

  // Selectors beyond the implemented register count behave as a fixed bank
  assign sel_valid = (e_sel != 3'd0) && (e_sel <= 3'(NREG));
  assign sel_idx   = 2'(e_sel - 3'd1);
  assign hot_idx   = 2'(32'(address_in[3:2]) % NREG);
  assign bank_num  = (sel_valid ? (bank_vec[sel_idx] + e_bank) : e_bank) & cfg_bank_mask;

  // Wide intermediates give zero-extension or truncation to ROM_AW for free
  assign flat_off      = address_in - cfg_offset;
  assign banked_wide   = {{ROM_AW{1'b0}}, bank_num, address_in[LOW_W-1:0]};
  assign flat_wide     = {{ROM_AW{1'b0}}, flat_off};
  assign rom_addr_calc = (e_type == T_BANK) ? banked_wide[ROM_AW-1:0] : flat_wide[ROM_AW-1:0];

  // Bank-register updates only happen for accesses taken in IDLE
  assign upd_data = idle & access & ~rw & (cfg_mode == 2'd1) & (e_type == T_BANK) & sel_valid;
  assign upd_hot  = idle & bus_strobe & (cfg_mode == 2'd2) & (address_in[15:4] == HOT_BASE);

  assign ram_addr = address_in[RAM_AW-1:0];
  assign ram_we   = idle & access & ~rw & (e_type == T_RAM);
  assign ram_re   = idle & access &  rw & (e_type == T_RAM);

  genvar gi;

  // Window table: one register per entry, new contents usable next cycle
  generate
    for (gi = 0; gi < NWIN; gi++) begin : g_win
      logic [ENT_W-1:0] ent_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          ent_reg <= '0;
        else if (cfg_we && (cfg_win == WIN_BITS'(gi)))
          ent_reg <= {cfg_type, cfg_sel, cfg_bank};
      end
      assign table_vec[gi] = ent_reg;
    end
  endgenerate

  // Bank registers; unimplemented slots read as zero
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      if (gi < NREG) begin : g_live
        logic [BANK_W-1:0] bank_val_reg;
        always_ff @(posedge clock or posedge reset) begin
          if (reset)
            bank_val_reg <= '0;
          else if (upd_data && (sel_idx == 2'(gi)))
            bank_val_reg <= din[BANK_W-1:0];
          else if (upd_hot && (hot_idx == 2'(gi)))
            bank_val_reg <= BANK_W'(address_in[1:0]);
        end
        assign bank_vec[gi] = bank_val_reg;
      end else begin : g_tie
        assign bank_vec[gi] = '0;
      end
    end
  endgenerate

  // Cart RAM with registered read port (block-RAM friendly, no reset)
  always_ff @(posedge clock) begin
    if (ram_we)
      ram[ram_addr] <= din;
    if (ram_re)
      ram_q_reg <= ram[ram_addr];
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      rom_address_reg <= '0;
      dout_reg        <= '0;
      dout_oe_reg     <= 1'b0;
      dout_ram_reg    <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rom_address_reg <= rom_address_next;
      dout_reg        <= dout_next;
      dout_oe_reg     <= dout_oe_next;
      dout_ram_reg    <= dout_ram_next;
      overrun_reg     <= overrun_next;
    end
  end

  // Next-state logic: accept accesses in IDLE, wait for ROM data in WAIT
  always_comb begin
    state_next       = state_reg;
    rom_address_next = rom_address_reg;
    dout_next        = dout_reg;
    dout_oe_next     = dout_oe_reg;
    dout_ram_next    = dout_ram_reg;
    overrun_next     = overrun_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus_strobe) begin
          dout_oe_next = 1'b0;
          if (access && rw) begin
            if ((e_type == T_FLAT) || (e_type == T_BANK)) begin
              rom_address_next = rom_addr_calc;
              state_next       = ST_WAIT;
            end else if (e_type == T_RAM) begin
              dout_oe_next  = 1'b1;
              dout_ram_next = 1'b1;
            end
          end
        end
      end
      ST_WAIT: begin
        if (bus_strobe)
          overrun_next = 1'b1;
        if (rom_ack) begin
          dout_next     = rom_din;
          dout_ram_next = 1'b0;
          dout_oe_next  = 1'b1;
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rom_req     = (state_reg == ST_WAIT);
  assign busy        = (state_reg == ST_WAIT);
  assign rom_address = rom_address_reg;
  assign dout        = dout_ram_reg ? ram_q_reg : dout_reg;
  assign dout_oe     = dout_oe_reg;
  assign overrun     = overrun_reg;
  assign pokey_cs    = idle & access & (e_type == T_POKEY);

endmodule
